// File: rtl/nibble_add_pkg.sv
// rtl/nibble_add_pkg.sv - shared types and helpers for the nibble-serial adder
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  // Index width for a nibble counter; never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// rtl/nibble_add4.sv - combinational 4-bit ripple-carry slice with carry-into-MSB tap
module nibble_add4
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a4_i,
  input  logic [NIB_W-1:0] b4_i,
  input  logic             ci_i,
  output logic [NIB_W-1:0] s4_o,
  output logic             co_o,
  output logic             c3_o
);

  logic c;

  always_comb begin
    c    = ci_i;
    s4_o = '0;
    c3_o = 1'b0;
    for (int i = 0; i < NIB_W; i++) begin
      if (i == NIB_W - 1) c3_o = c;
      s4_o[i] = a4_i[i] ^ b4_i[i] ^ c;
      c       = (a4_i[i] & b4_i[i]) | (c & (a4_i[i] ^ b4_i[i]));
    end
    co_o = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit adder sequenced one nibble per clock, LSB first
// Optional signed-overflow flag port/logic enabled by defining ADD_OVF_FLAG_EN.
module nibble_serial_adder_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [NIB_W-1:0] slice_s;
  logic             slice_co;
`ifdef ADD_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
  logic             slice_c3;
`else
  logic             unused_slice_c3;
`endif

  nibble_add4 u_slice (
    .a4_i (a_q[NIB_W*idx_q +: NIB_W]),
    .b4_i (b_q[NIB_W*idx_q +: NIB_W]),
    .ci_i (carry_q),
    .s4_o (slice_s),
    .co_o (slice_co),
`ifdef ADD_OVF_FLAG_EN
    .c3_o (slice_c3)
`else
    .c3_o (unused_slice_c3)
`endif
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef ADD_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef ADD_OVF_FLAG_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[NIB_W*idx_q +: NIB_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = slice_co;
`ifdef ADD_OVF_FLAG_EN
          ovf_d   = slice_c3 ^ slice_co;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADD_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ADD_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // rst_n gates in_ready so upstream never sees a handshake while reset is held.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef ADD_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - self-checking bench for nibble_serial_adder_ctrl (WIDTH=16)
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADD_OVF_FLAG_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADD_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Reference: full-precision arithmetic, result = {cout, sum}.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Two's-complement overflow: same-sign operands producing a different-sign result.
  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
    logic [WIDTH:0] r;
    r = ref_add(x, y, c);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Offer operands until accepted (bounded); returns at accept edge + 1.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                       output bit acc);
    acc = 1'b0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    for (int i = 0; i < 12 && !acc; i++) begin
      if (in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef ADD_OVF_FLAG_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    bit acc;
    int lat;
    logic [WIDTH:0] exp;
    exp = ref_add(av, bv, cv);
    issue(av, bv, cv, acc);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b want 1", acc); end
    wait_result(lat);
    n_cmp++; if (lat != NIBBLES) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, NIBBLES); end
    n_cmp++; if (sum !== exp[WIDTH-1:0]) begin n_err++; $display("FAIL basic_sum: got %h want %h", sum, exp[WIDTH-1:0]); end
    n_cmp++; if (cout !== exp[WIDTH]) begin n_err++; $display("FAIL basic_cout: got %b want %b", cout, exp[WIDTH]); end
    release_result();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_hold;
    bit acc;
    int lat;
    bit bad;
    issue(16'h0000, 16'h0000, 1'b1, acc);
    wait_result(lat);
    n_cmp++; if (sum !== 16'h0001 || cout !== 1'b0) begin
      n_err++; $display("FAIL hold_result: got sum=%h cout=%b want 0001/0", sum, cout);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || sum !== 16'h0001 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL hold_stable: got out_valid=%b sum=%h in_ready=%b want 1/0001/0", out_valid, sum, in_ready); end
    release_result();
  endtask

  task automatic test_ignore_in_valid;
    bit acc;
    int lat;
    bit bad;
    issue(16'h1234, 16'h4321, 1'b0, acc);
    lat = 0;
    bad = 1'b0;
    while (!out_valid && lat < 20) begin
      in_valid = ~in_valid;
      a = 16'hAAAA;
      b = 16'hAAAA;
      cin = 1'b1;
      if (in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    n_cmp++; if (bad) begin n_err++; $display("FAIL ignore_in_ready: got in_ready=1 during RUN want 0"); end
    n_cmp++; if (lat != NIBBLES) begin n_err++; $display("FAIL ignore_latency: got %0d want %0d", lat, NIBBLES); end
    n_cmp++; if (sum !== 16'h5555 || cout !== 1'b0) begin
      n_err++; $display("FAIL ignore_sum: got sum=%h cout=%b want 5555/0", sum, cout);
    end
    release_result();
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL ignore_no_second_accept: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run;
    bit acc;
    bit bad;
    issue(16'h1234, 16'h4321, 1'b0, acc);
    @(posedge clk);
    #1;
    n_cmp++; if (sum !== 16'h0005) begin n_err++; $display("FAIL midrun_partial_sum: got %h want 0005", sum); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL midrun_async_reset: got out_valid=%b sum=%h in_ready=%b want 0/0000/0", out_valid, sum, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrun_release_in_ready: got %b want 1", in_ready); end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || sum !== '0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL midrun_stale_result: got out_valid=%b sum=%h want 0/0000", out_valid, sum); end
  endtask

  task automatic test_back_to_back;
    bit acc;
    int lat;
    logic [WIDTH:0] exp;
    issue(16'h0F0F, 16'h0101, 1'b0, acc);
    wait_result(lat);
    exp = ref_add(16'hBEEF, 16'h1111, 1'b1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'hBEEF;
    b = 16'h1111;
    cin = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_not_yet_accepted: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got in_ready=%b want 0", in_ready); end
    wait_result(lat);
    n_cmp++; if (lat != NIBBLES) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", lat, NIBBLES); end
    n_cmp++; if (sum !== exp[WIDTH-1:0] || cout !== exp[WIDTH]) begin
      n_err++; $display("FAIL b2b_result: got sum=%h cout=%b want %h/%b", sum, cout, exp[WIDTH-1:0], exp[WIDTH]);
    end
    release_result();
  endtask

  task automatic test_random;
    bit acc;
    int lat;
    logic [WIDTH-1:0] av, bv;
    logic cv;
    logic [WIDTH:0] exp;
    for (int n = 0; n < 24; n++) begin
      av = WIDTH'($urandom);
      bv = WIDTH'($urandom);
      cv = 1'($urandom_range(0, 1));
      if (n == 0) begin av = 16'hFFFF; bv = 16'hFFFF; cv = 1'b1; end
      exp = ref_add(av, bv, cv);
      issue(av, bv, cv, acc);
      n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL rand_accept[%0d]: got %b want 1", n, acc); end
      wait_result(lat);
      n_cmp++; if (lat != NIBBLES) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, NIBBLES); end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      n_cmp++; if (out_valid !== 1'b1 || sum !== exp[WIDTH-1:0] || cout !== exp[WIDTH]) begin
        n_err++; $display("FAIL rand_result[%0d]: %h+%h+%b got v=%b sum=%h cout=%b want 1/%h/%b",
                          n, av, bv, cv, out_valid, sum, cout, exp[WIDTH-1:0], exp[WIDTH]);
      end
`ifdef ADD_OVF_FLAG_EN
      n_cmp++; if (ovf !== ref_ovf(av, bv, cv)) begin
        n_err++; $display("FAIL rand_ovf[%0d]: got %b want %b", n, ovf, ref_ovf(av, bv, cv));
      end
`endif
      release_result();
    end
  endtask

`ifdef ADD_OVF_FLAG_EN
  task automatic test_ovf;
    bit acc;
    int lat;
    issue(16'h7FFF, 16'h0001, 1'b0, acc);
    wait_result(lat);
    n_cmp++; if (ovf !== 1'b1 || sum !== 16'h8000) begin
      n_err++; $display("FAIL ovf_pos: got ovf=%b sum=%h want 1/8000", ovf, sum);
    end
    release_result();
    issue(16'hFFFF, 16'h0001, 1'b0, acc);
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear_on_accept: got %b want 0", ovf); end
    wait_result(lat);
    n_cmp++; if (ovf !== 1'b0 || sum !== 16'h0000 || cout !== 1'b1) begin
      n_err++; $display("FAIL ovf_neg: got ovf=%b sum=%h cout=%b want 0/0000/1", ovf, sum, cout);
    end
    release_result();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic(16'h1234, 16'h4321, 1'b0);
    test_basic(16'hFFFF, 16'h0001, 1'b0);
    test_hold();
    test_ignore_in_valid();
    test_reset_mid_run();
    test_back_to_back();
`ifdef ADD_OVF_FLAG_EN
    test_ovf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
